// File: rtl/otf_pkg.sv
// Shared types and helpers for the on-the-fly signed-digit receivers.
// Holds the FSM state encoding, the digit encodings and the counter sizing rule.
package otf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // {d_plus, d_minus}; 2'b11 is a legal redundant zero and falls under "zero".
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  // The counter only has to reach max(N, DELAY) - 1.
  function automatic int count_width(input int n, input int delay);
    int m;
    m = (n > delay) ? n : delay;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/otf_sd_converter_if.sv
// Digit-in / word-out port bundle of the signed-digit converter.
// Handshake: a word transfers on a rising edge where out_valid=1 and out_ready=1;
// out_valid never drops and out_data never changes until that edge has happened.
interface otf_sd_converter_if #(
  parameter int N = 8
);

  logic         start;
  logic         d_plus;
  logic         d_minus;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out_data;

  modport master (
    output start, d_plus, d_minus, out_ready,
    input  busy, out_valid, out_data
  );

  modport slave (
    input  start, d_plus, d_minus, out_ready,
    output busy, out_valid, out_data
  );

endinterface

// File: rtl/otf_digit_update.sv
// One step of on-the-fly conversion: folds one signed digit into the Q / QM pair,
// where QM always equals Q - 1 ulp so a -1 digit needs no borrow propagation.
module otf_digit_update
  import otf_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0] q_i,
  input  logic [N:0] qm_i,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic [N:0] q_o,
  output logic [N:0] qm_o
);

  logic [N:0] q_sh;
  logic [N:0] qm_sh;

  assign q_sh  = q_i << 1;
  assign qm_sh = qm_i << 1;

  always_comb begin
    q_o  = q_sh;
    qm_o = qm_sh | {{N{1'b0}}, 1'b1};
    case ({d_plus, d_minus})
      DIG_POS: begin
        q_o  = q_sh | {{N{1'b0}}, 1'b1};
        qm_o = q_sh;
      end
      DIG_NEG: begin
        q_o  = qm_sh | {{N{1'b0}}, 1'b1};
        qm_o = qm_sh;
      end
      default: begin
        q_o  = q_sh;
        qm_o = qm_sh | {{N{1'b0}}, 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/otf_sd_converter.sv
// Receive-side terminator: drops DELAY leading digits, converts N MSD-first signed
// digits into an (N+1)-bit two's-complement fraction and holds it on a valid/ready port.
module otf_sd_converter
  import otf_pkg::*;
#(
  parameter int N     = 8,
  parameter int DELAY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  otf_sd_converter_if.slave         io,
  output state_t                    dbg_state
);

  localparam int CW             = count_width(N, DELAY);
  localparam int SKIP_LAST_I    = (DELAY > 0) ? DELAY - 1 : 0;
  localparam int COLLECT_LAST_I = N - 1;
  localparam logic [CW-1:0] SKIP_LAST    = SKIP_LAST_I[CW-1:0];
  localparam logic [CW-1:0] COLLECT_LAST = COLLECT_LAST_I[CW-1:0];
  localparam state_t        FIRST_STATE  = (DELAY == 0) ? COLLECT : SKIP;

  state_t        state_q,     state_d;
  logic [CW-1:0] count_q,     count_d;
  logic [N:0]    q_q,         q_d;
  logic [N:0]    qm_q,        qm_d;
  logic [N:0]    out_data_q,  out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q,      busy_d;

  logic [N:0]    q_nxt;
  logic [N:0]    qm_nxt;

  otf_digit_update #(.N(N)) u_digit_update (
    .q_i     (q_q),
    .qm_i    (qm_q),
    .d_plus  (io.d_plus),
    .d_minus (io.d_minus),
    .q_o     (q_nxt),
    .qm_o    (qm_nxt)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    q_d         = q_q;
    qm_d        = qm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d = FIRST_STATE;
          count_d = '0;
          q_d     = '0;
          qm_d    = '1;
        end
      end
      SKIP: begin
        if (count_q == SKIP_LAST) begin
          state_d = COLLECT;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      COLLECT: begin
        q_d  = q_nxt;
        qm_d = qm_nxt;
        if (count_q == COLLECT_LAST) begin
          state_d     = HOLD;
          out_data_d  = q_nxt;
          out_valid_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      HOLD: begin
        // Start is only honoured together with the acceptance of the held word.
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          if (io.start) begin
            state_d = FIRST_STATE;
            count_d = '0;
            q_d     = '0;
            qm_d    = '1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SKIP) || (state_d == COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      q_q         <= '0;
      qm_q        <= '1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      q_q         <= q_d;
      qm_q        <= qm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign io.out_data  = out_data_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_otf_sd_converter.sv
// Bench for otf_sd_converter: a DELAY=2 and a DELAY=0 instance, directed cases plus
// random words checked against an arithmetic model of the signed-digit value.
module tb_otf_sd_converter;
  import otf_pkg::*;

  localparam int N = 8;

  typedef logic [1:0] word_t [N];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otf_sd_converter_if #(.N(N)) a_if ();
  otf_sd_converter_if #(.N(N)) b_if ();
  state_t a_state;
  state_t b_state;

  otf_sd_converter #(.N(N), .DELAY(2)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (a_if.slave),
    .dbg_state (a_state)
  );

  otf_sd_converter #(.N(N), .DELAY(0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (b_if.slave),
    .dbg_state (b_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [N:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Value of the digit string times 2^N, wrapped to N+1 bits.
  function automatic logic [N:0] ref_word(input word_t w);
    int v;
    v = 0;
    for (int i = 0; i < N; i++) v = v * 2 + (int'(w[i][1]) - int'(w[i][0]));
    return v[N:0];
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < N; i++) w[i] = 2'($urandom_range(0, 3));
    return w;
  endfunction

  function automatic word_t fill_word(input logic [1:0] e);
    word_t w;
    for (int i = 0; i < N; i++) w[i] = e;
    return w;
  endfunction

  // ---------------- drivers for the DELAY=2 instance ----------------
  task automatic a_start();
    a_if.start     = 1'b1;
    a_if.out_ready = 1'b0;
    {a_if.d_plus, a_if.d_minus} = 2'($urandom_range(0, 3));
    @(negedge clk);
    a_if.start = 1'b0;
  endtask

  // Entered on the negedge right after the edge that accepted start.
  task automatic a_collect(input word_t w, input string tag);
    logic [N:0] exp;
    exp_q.push_back(ref_word(w));
    for (int j = 0; j < 2; j++) begin
      {a_if.d_plus, a_if.d_minus} = 2'($urandom_range(0, 3));
      a_if.start     = 1'($urandom_range(0, 1));
      a_if.out_ready = 1'($urandom_range(0, 1));
      check({tag, "_skip_busy"}, 32'(a_if.busy), 32'd1);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      {a_if.d_plus, a_if.d_minus} = w[i];
      a_if.start     = 1'($urandom_range(0, 1));
      a_if.out_ready = 1'($urandom_range(0, 1));
      check({tag, "_collect_busy"}, 32'(a_if.busy), 32'd1);
      check({tag, "_collect_novalid"}, 32'(a_if.out_valid), 32'd0);
      @(negedge clk);
    end
    a_if.start     = 1'b0;
    a_if.out_ready = 1'b0;
    exp = exp_q.pop_front();
    check({tag, "_valid"}, 32'(a_if.out_valid), 32'd1);
    check({tag, "_data"}, 32'(a_if.out_data), 32'(exp));
    check({tag, "_hold_busy"}, 32'(a_if.busy), 32'd0);
    check({tag, "_hold_state"}, 32'(a_state), 32'(HOLD));
  endtask

  task automatic a_release(input int stall, input bit b2b, input logic [N:0] exp, input string tag);
    for (int k = 0; k < stall; k++) begin
      a_if.out_ready = 1'b0;
      a_if.start     = 1'($urandom_range(0, 1));
      {a_if.d_plus, a_if.d_minus} = 2'($urandom_range(0, 3));
      @(negedge clk);
      check({tag, "_stall_valid"}, 32'(a_if.out_valid), 32'd1);
      check({tag, "_stall_data"}, 32'(a_if.out_data), 32'(exp));
    end
    a_if.out_ready = 1'b1;
    a_if.start     = b2b;
    @(negedge clk);
    a_if.out_ready = 1'b0;
    a_if.start     = 1'b0;
    check({tag, "_released_valid"}, 32'(a_if.out_valid), 32'd0);
    check({tag, "_released_state"}, 32'(a_state), b2b ? 32'(SKIP) : 32'(IDLE));
    check({tag, "_released_busy"}, 32'(a_if.busy), 32'(b2b));
  endtask

  // ---------------- driver for the DELAY=0 instance ----------------
  task automatic b_run(input word_t w, input string tag);
    logic [N:0] exp;
    exp = ref_word(w);
    b_if.start = 1'b1;
    {b_if.d_plus, b_if.d_minus} = 2'($urandom_range(0, 3));
    @(negedge clk);
    b_if.start = 1'b0;
    for (int i = 0; i < N; i++) begin
      {b_if.d_plus, b_if.d_minus} = w[i];
      check({tag, "_busy"}, 32'(b_if.busy), 32'd1);
      check({tag, "_novalid"}, 32'(b_if.out_valid), 32'd0);
      @(negedge clk);
    end
    check({tag, "_valid"}, 32'(b_if.out_valid), 32'd1);
    check({tag, "_data"}, 32'(b_if.out_data), 32'(exp));
    b_if.out_ready = 1'b1;
    @(negedge clk);
    b_if.out_ready = 1'b0;
    check({tag, "_released_valid"}, 32'(b_if.out_valid), 32'd0);
    check({tag, "_released_state"}, 32'(b_state), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    word_t w;
    logic [N:0] exp;
    bit pending;

    a_if.start = 1'b0; a_if.d_plus = 1'b0; a_if.d_minus = 1'b0; a_if.out_ready = 1'b0;
    b_if.start = 1'b0; b_if.d_plus = 1'b0; b_if.d_minus = 1'b0; b_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_a_data", 32'(a_if.out_data), 32'd0);
    check("rst_a_busy", 32'(a_if.busy), 32'd0);
    check("rst_a_state", 32'(a_state), 32'(IDLE));
    check("rst_b_data", 32'(b_if.out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 95/256 with backpressure while start and digits toggle.
    w = '{DIG_POS, DIG_NEG, DIG_POS, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_NEG};
    a_start();
    a_collect(w, "d95");
    check("d95_const", 32'(a_if.out_data), 32'h05F);
    a_release(5, 1'b0, 9'h05F, "d95");

    a_start();
    a_collect(fill_word(DIG_NEG), "all_neg");
    check("all_neg_const", 32'(a_if.out_data), 32'h101);
    a_release(0, 1'b0, 9'h101, "all_neg");

    a_start();
    a_collect(fill_word(DIG_POS), "all_pos");
    check("all_pos_const", 32'(a_if.out_data), 32'h0FF);
    a_release(0, 1'b0, 9'h0FF, "all_pos");

    a_start();
    a_collect(fill_word(2'b11), "all_rz");
    check("all_rz_const", 32'(a_if.out_data), 32'h000);
    check("idle_holds_data_pre", 32'(a_if.out_data), 32'h000);
    a_release(1, 1'b0, 9'h000, "all_rz");

    // Back-to-back restart in the accepting HOLD cycle.
    a_start();
    a_collect(fill_word(DIG_POS), "b2b_first");
    a_release(0, 1'b1, 9'h0FF, "b2b_first");
    w = '{DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_POS};
    a_collect(w, "b2b_second");
    check("b2b_second_const", 32'(a_if.out_data), 32'h001);
    a_release(0, 1'b0, 9'h001, "b2b_second");
    repeat (3) @(negedge clk);
    check("idle_holds_data", 32'(a_if.out_data), 32'h001);

    // Reset at COLLECT digit 4: outputs clear immediately, no residue afterwards.
    a_start();
    repeat (2 + 4) begin
      {a_if.d_plus, a_if.d_minus} = DIG_POS;
      @(negedge clk);
    end
    check("mid_busy_before_rst", 32'(a_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(a_if.out_valid), 32'd0);
    check("mid_rst_busy", 32'(a_if.busy), 32'd0);
    check("mid_rst_data", 32'(a_if.out_data), 32'd0);
    check("mid_rst_state", 32'(a_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = '{DIG_ZERO, DIG_NEG, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO};
    a_start();
    a_collect(w, "post_rst");
    check("post_rst_const", 32'(a_if.out_data), 32'h1C0);
    a_release(0, 1'b0, 9'h1C0, "post_rst");

    // Random words, random backpressure, random back-to-back restarts.
    pending = 1'b0;
    for (int it = 0; it < 40; it++) begin
      w = rand_word();
      exp = ref_word(w);
      if (!pending) a_start();
      a_collect(w, "rand");
      pending = 1'($urandom_range(0, 1));
      a_release($urandom_range(0, 3), pending, exp, "rand");
    end
    if (pending) begin
      w = rand_word();
      exp = ref_word(w);
      a_collect(w, "rand_tail");
      a_release(0, 1'b0, exp, "rand_tail");
    end

    // DELAY=0 instance.
    w = '{DIG_NEG, DIG_POS, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO, DIG_ZERO};
    b_run(w, "nodelay_m64");
    check("nodelay_m64_const", 32'(b_if.out_data), 32'h1C0);
    for (int it = 0; it < 8; it++) b_run(rand_word(), "nodelay_rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1);
  end

endmodule
